block_accumulator: RTL and testbench

- Upstream feeder for the rounding divider.
- Sums each group of 2^DIV_LOG2 consecutive OUT_WIDTH-bit samples into one IN_WIDTH-bit total. The downstream divide-by-2^DIV_LOG2 stage then produces the rounded block average.
- Valid/ready on both sides; single-entry output register.
- Accumulation of the next block overlaps with the previous total waiting at the output.

---
 rtl/block_accumulator.sv | 79 +++++++
 tb/tb_block_accumulator.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/block_accumulator.sv
// Sums each group of 2**DIV_LOG2 unsigned samples into one block total held in a
// single-entry valid/ready output register; the next block accumulates while a total waits.
module block_accumulator #(
    parameter int DIV_LOG2  = 3,
    parameter int OUT_WIDTH = 8,
    parameter int IN_WIDTH  = OUT_WIDTH + DIV_LOG2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 din_valid,
    output logic                 din_ready,
    input  logic [OUT_WIDTH-1:0] din,
    output logic                 sum_valid,
    input  logic                 sum_ready,
    output logic [IN_WIDTH-1:0]  sum
);

    logic [DIV_LOG2-1:0] cnt_q, cnt_d;
    logic [IN_WIDTH-1:0] acc_q, acc_d;
    logic [IN_WIDTH-1:0] sum_q, sum_d;
    logic                sum_valid_q, sum_valid_d;

    logic                last;
    logic                accept;
    logic                drain;
    logic [IN_WIDTH-1:0] acc_plus;

    assign last      = &cnt_q;
    assign din_ready = !clear && (!last || !sum_valid_q || sum_ready);
    assign accept    = din_valid && din_ready;
    assign drain     = sum_valid_q && sum_ready;
    assign acc_plus  = acc_q + IN_WIDTH'(din);

    assign sum       = sum_q;
    assign sum_valid = sum_valid_q;

    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        sum_valid_d = sum_valid_q;

        if (drain) begin
            sum_valid_d = 1'b0;
        end

        // clear forces din_ready low, so it never coincides with an accept
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            if (last) begin
                sum_d       = acc_plus;
                sum_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
            end else begin
                acc_d = acc_plus;
                cnt_d = cnt_q + DIV_LOG2'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
        end
    end

endmodule

// File: tb/tb_block_accumulator.sv
// Bench for block_accumulator: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of block totals and the output handshake.
module tb_block_accumulator;

    localparam int DIV_LOG2 = 3;
    localparam int N        = 1 << DIV_LOG2;
    localparam int OW       = 8;
    localparam int IW       = OW + DIV_LOG2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clear = 1'b0;
    logic          din_valid = 1'b0;
    logic          din_ready;
    logic [OW-1:0] din = '0;
    logic          sum_valid;
    logic          sum_ready = 1'b0;
    logic [IW-1:0] sum;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // model state
    int blk_q[$];
    bit m_valid = 1'b0;
    int m_sum   = 0;
    int hs_cnt  = 0;

    block_accumulator #(.DIV_LOG2(DIV_LOG2), .OUT_WIDTH(OW), .IN_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .din_valid(din_valid), .din_ready(din_ready), .din(din),
        .sum_valid(sum_valid), .sum_ready(sum_ready), .sum(sum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_ready();
        return !clear && ((blk_q.size() != N - 1) || !m_valid || sum_ready);
    endfunction

    // Model: a block is the list of samples taken so far; its total is their plain sum.
    always @(posedge clk) begin
        bit completed;
        bit drained;
        int s;
        completed = 1'b0;
        if (!rst) begin
            blk_q.delete();
            m_valid = 1'b0;
            m_sum   = 0;
        end else begin
            drained = m_valid && sum_ready;
            if (drained) hs_cnt++;
            if (clear) begin
                blk_q.delete();
            end else if (din_valid && exp_ready()) begin
                blk_q.push_back(int'(din));
                if (blk_q.size() == N) begin
                    s = 0;
                    foreach (blk_q[i]) s += blk_q[i];
                    m_sum     = s;
                    m_valid   = 1'b1;
                    completed = 1'b1;
                    blk_q.delete();
                end
            end
            if (drained && !completed) m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("din_ready", 32'(din_ready), 32'(exp_ready()));
            chk("sum_valid", 32'(sum_valid), 32'(m_valid));
            chk("sum", 32'(sum), 32'(m_sum));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int v, input bit gaps);
        int  budget;
        bit  done;
        budget = 0;
        done   = 1'b0;
        if (gaps) begin
            din_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        din_valid = 1'b1;
        din       = OW'(v);
        while (!done) begin
            @(negedge clk);
            done = din_ready;
            tick();
            budget++;
            if (!done && budget > 50) begin
                chk("push_timeout", 32'(budget), 32'(0));
                done = 1'b1;
            end
        end
        din_valid = 1'b0;
    endtask

    initial begin
        int hs0;

        // reset
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        chk_en = 1'b1;
        chk("reset_sum_valid", 32'(sum_valid), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_din_ready", 32'(din_ready), 32'd1);

        // eight back-to-back 255s
        sum_ready = 1'b1;
        for (int i = 0; i < N; i++) push(255, 1'b0);
        chk("max_sum", 32'(sum), 32'd2040);
        chk("max_valid", 32'(sum_valid), 32'd1);
        tick();
        chk("max_valid_pulse", 32'(sum_valid), 32'd0);

        // 10..80 with gaps, then zeros
        for (int i = 1; i <= N; i++) push(10 * i, 1'b1);
        chk("ramp_sum", 32'(sum), 32'd360);
        for (int i = 0; i < N; i++) push(0, 1'b1);
        chk("zero_sum", 32'(sum), 32'd0);
        chk("zero_valid", 32'(sum_valid), 32'd1);
        tick();

        // backpressure: held total, 7 more accepted, 16th stalls
        sum_ready = 1'b0;
        for (int i = 0; i < N; i++) push(1, 1'b0);
        chk("bp_first_sum", 32'(sum), 32'd8);
        for (int i = 0; i < N - 1; i++) push(1, 1'b0);
        chk("bp_held_sum", 32'(sum), 32'd8);
        chk("bp_held_valid", 32'(sum_valid), 32'd1);
        din_valid = 1'b1;
        din       = 8'd1;
        @(negedge clk);
        chk("bp_stall", 32'(din_ready), 32'd0);
        tick();
        @(negedge clk);
        chk("bp_stall2", 32'(din_ready), 32'd0);
        tick();
        hs0 = hs_cnt;
        sum_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", 32'(din_ready), 32'd1);
        tick();
        sum_ready = 1'b0;
        din_valid = 1'b0;
        chk("bp_second_valid", 32'(sum_valid), 32'd1);
        chk("bp_second_sum", 32'(sum), 32'd8);
        chk("bp_handshakes", 32'(hs_cnt - hs0), 32'd1);
        sum_ready = 1'b1;
        tick();
        chk("bp_drained", 32'(sum_valid), 32'd0);

        // simultaneous drain and completion
        sum_ready = 1'b0;
        for (int i = 0; i < N; i++) push(1, 1'b0);
        for (int i = 0; i < N - 1; i++) push(5, 1'b1);
        hs0 = hs_cnt;
        sum_ready = 1'b1;
        push(5, 1'b0);
        chk("overlap_valid", 32'(sum_valid), 32'd1);
        chk("overlap_sum", 32'(sum), 32'd40);
        tick();
        sum_ready = 1'b0;
        chk("overlap_handshakes", 32'(hs_cnt - hs0), 32'd2);
        chk("overlap_empty", 32'(sum_valid), 32'd0);

        // clear discards partial block, held total survives
        for (int i = 0; i < N; i++) push(2, 1'b0);
        for (int i = 0; i < 5; i++) push(100, 1'b0);
        clear     = 1'b1;
        din_valid = 1'b1;
        din       = 8'd100;
        @(negedge clk);
        chk("clear_blocks", 32'(din_ready), 32'd0);
        tick();
        clear     = 1'b0;
        din_valid = 1'b0;
        chk("clear_held_sum", 32'(sum), 32'd16);
        chk("clear_held_valid", 32'(sum_valid), 32'd1);
        sum_ready = 1'b1;
        for (int i = 0; i < N; i++) push(3, 1'b0);
        chk("clear_sum", 32'(sum), 32'd24);
        tick();

        // reset mid-block with a held total
        sum_ready = 1'b0;
        for (int i = 0; i < N; i++) push(9, 1'b0);
        for (int i = 0; i < 4; i++) push(50, 1'b0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("rst_valid", 32'(sum_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        sum_ready = 1'b1;
        for (int i = 0; i < N; i++) push(7, 1'b0);
        chk("rst_sum_after", 32'(sum), 32'd56);
        tick();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            din_valid = ($urandom_range(0, 3) != 0);
            din       = OW'($urandom);
            sum_ready = ($urandom_range(0, 2) != 0);
            clear     = ($urandom_range(0, 40) == 0);
            rst       = ($urandom_range(0, 400) != 0);
            tick();
        end
        rst       = 1'b1;
        clear     = 1'b0;
        din_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
